// File: rtl/shift_pkg.sv
// Shared shift-link definitions: receive FSM states and
// serial direction codes used by both link endpoints.
package shift_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_shift_core.sv
// Serial-in parallel-out shifter with per-frame direction,
// bit counter and a combinational frame-complete pulse.
module sipo_shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             shift,
    input  logic             bit_in,
    input  logic             msb_first,
    output logic [WIDTH-1:0] word,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] sr_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             dir;
    logic             dir_eff;
    logic             take;

    // A start discards the partial word and uses the new direction.
    always_comb begin
        take    = start | shift;
        sr_base = start ? '0 : sr;
        dir_eff = start ? msb_first : dir;
        cnt_nxt = start ? CW'(1) : cnt + 1'b1;
        if (dir_eff == DIR_MSB_FIRST)
            sr_nxt = {sr_base[WIDTH-2:0], bit_in};
        else
            sr_nxt = {bit_in, sr_base[WIDTH-1:1]};
        done = take && (cnt_nxt == CW'(WIDTH));
        word = sr_nxt;
    end

    // Shifter, counter and latched direction.
    always_ff @(posedge clk) begin
        if (clear) begin
            sr  <= '0;
            cnt <= '0;
            dir <= DIR_LSB_FIRST;
        end else if (take) begin
            sr  <= sr_nxt;
            cnt <= done ? '0 : cnt_nxt;
            if (start)
                dir <= msb_first;
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial word receiver: framing FSM, one-entry valid/ready
// output buffer and sticky overrun / frame error flags.
module serial_word_receiver
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             ser_valid,
    input  logic             ser_data,
    input  logic             ser_start,
    input  logic             msb_first,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             flag_clr
);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             core_start;
    logic             core_shift;
    logic             core_done;
    logic [WIDTH-1:0] core_word;
    logic             fe_set;
    logic             ov_set;
    logic             consume;

    sipo_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (CLK),
        .clear    (Clear),
        .start    (core_start),
        .shift    (core_shift),
        .bit_in   (ser_data),
        .msb_first(msb_first),
        .word     (core_word),
        .done     (core_done)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (Clear)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and shifter control.
    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        core_shift = 1'b0;
        fe_set     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ser_valid && ser_start) begin
                    core_start = 1'b1;
                    state_nxt  = RECV;
                end
            end
            RECV: begin
                if (ser_valid) begin
                    if (ser_start) begin
                        core_start = 1'b1;
                        fe_set     = 1'b1;
                    end else begin
                        core_shift = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (core_done)
            state_nxt = IDLE;
    end

    assign busy    = (state == RECV);
    assign consume = word_valid & word_ready;
    assign ov_set  = core_done & word_valid & ~consume;

    // Output buffer: a full, unconsumed buffer drops new words.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (core_done && (!word_valid || consume)) begin
            word_out   <= core_word;
            word_valid <= 1'b1;
        end else if (consume) begin
            word_valid <= 1'b0;
        end
    end

    // Sticky flags; a set beats a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ov_set)
                overrun <= 1'b1;
            else if (flag_clr)
                overrun <= 1'b0;
            if (fe_set)
                frame_err <= 1'b1;
            else if (flag_clr)
                frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver (WIDTH=4):
// directed frames, monitor checks every consumed word.
module tb_serial_word_receiver;

    logic       CLK = 1'b0;
    logic       Clear = 1'b1;
    logic       ser_valid = 1'b0;
    logic       ser_data = 1'b0;
    logic       ser_start = 1'b0;
    logic       msb_first = 1'b0;
    logic [3:0] word_out;
    logic       word_valid;
    logic       word_ready = 1'b0;
    logic       busy;
    logic       overrun;
    logic       frame_err;
    logic       flag_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    serial_word_receiver #(
        .WIDTH(4)
    ) dut (
        .CLK       (CLK),
        .Clear     (Clear),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_start (ser_start),
        .msb_first (msb_first),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err),
        .flag_clr  (flag_clr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every consumed word must match the scoreboard head.
    always @(negedge CLK) begin
        if (!Clear && word_valid && word_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL word_unexpected: got %b, queue empty", word_out);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (word_out !== e) begin
                    n_bad++;
                    $display("FAIL word: got %b expected %b", word_out, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [3:0] got,
                         input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic send(input logic b, input logic st, input logic msb);
        @(posedge CLK);
        #1;
        ser_valid = 1'b1;
        ser_data  = b;
        ser_start = st;
        msb_first = msb;
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
        ser_valid = 1'b0;
        ser_start = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] w, input logic msb,
                              input bit gap);
        for (int i = 0; i < 4; i++) begin
            send(msb ? w[3-i] : w[i], i == 0, msb);
            if (gap && i < 3) begin
                idle();
                check("busy_gap", {3'b0, busy}, 4'd1);
            end
        end
    endtask

    initial begin
        // 1: reset and stray bits
        @(posedge CLK);
        @(posedge CLK);
        #1;
        Clear = 1'b0;
        check("rst_word", word_out, 4'b0000);
        check("rst_flags", {word_valid, busy, overrun, frame_err}, 4'b0000);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b1);
        idle();
        check("stray_word", word_out, 4'b0000);
        check("stray_flags", {word_valid, busy, overrun, frame_err}, 4'b0000);

        // 2: LSB-first 1,1,0,1 -> 1011, latency 1
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b0, 1'b0);
        check("t2_busy", {3'b0, busy}, 4'd1);
        idle();
        check("t2_valid", {3'b0, word_valid}, 4'd1);
        word_ready = 1'b1;
        idle();
        check("t2_consumed", {3'b0, word_valid}, 4'd0);

        // 3: MSB-first gapped, then back-to-back frame
        exp_q.push_back(4'b1011);
        exp_q.push_back(4'b0110);
        send_frame(4'b1011, 1'b1, 1'b1);
        send_frame(4'b0110, 1'b1, 1'b0);
        idle();
        idle();
        check("t3_overrun", {3'b0, overrun}, 4'd0);
        check("t3_queue", 4'(exp_q.size()), 4'd0);

        // 4: full buffer drops second word
        word_ready = 1'b0;
        send_frame(4'b1011, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0, 1'b0);
        idle();
        check("t4_word", word_out, 4'b1011);
        check("t4_flags", {word_valid, overrun}, 4'b0011);
        @(posedge CLK);
        #1;
        flag_clr = 1'b1;
        @(posedge CLK);
        #1;
        flag_clr = 1'b0;
        check("t4_ovclr", {3'b0, overrun}, 4'd0);
        exp_q.push_back(4'b1011);
        word_ready = 1'b1;
        idle();
        idle();
        check("t4_queue", 4'(exp_q.size()), 4'd0);

        // 5: restart mid-frame -> frame_err, only new word
        send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        exp_q.push_back(4'b1100);
        send_frame(4'b1100, 1'b0, 1'b0);
        idle();
        check("t5_ferr", {3'b0, frame_err}, 4'd1);
        check("t5_word", word_out, 4'b1100);
        idle();
        idle();
        check("t5_queue", 4'(exp_q.size()), 4'd0);
        @(posedge CLK);
        #1;
        flag_clr = 1'b1;
        @(posedge CLK);
        #1;
        flag_clr = 1'b0;
        check("t5_ferrclr", {3'b0, frame_err}, 4'd0);

        // 6: Clear mid-frame with a buffered word
        word_ready = 1'b0;
        send_frame(4'b0101, 1'b0, 1'b0);
        idle();
        check("t6_valid", {3'b0, word_valid}, 4'd1);
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        @(posedge CLK);
        #1;
        ser_valid = 1'b0;
        Clear = 1'b1;
        @(posedge CLK);
        #1;
        Clear = 1'b0;
        check("t6_word", word_out, 4'b0000);
        check("t6_flags", {word_valid, busy, overrun, frame_err}, 4'b0000);
        exp_q.push_back(4'b1001);
        send_frame(4'b1001, 1'b1, 1'b0);
        idle();
        check("t6_new", word_out, 4'b1001);
        word_ready = 1'b1;
        idle();
        idle();
        check("end_queue", 4'(exp_q.size()), 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
